lcd_digit_updater: RTL
======================

# lcd_digit_updater

Sits directly downstream of the time-keeping block and upstream of the LCD glyph writer. Takes the packed BCD time word, the 6-bit digit-changed mask and the write strobe. Converts each flagged digit into one glyph-draw command, issued over a valid/ready handshake. Coalesces updates that arrive while busy, so no digit change is lost and each digit is drawn with its latest value.

## Interface
Parameters:
- DIGIT_X0, 8: x coordinate of leftmost digit (H2)
- DIGIT_PITCH, 16: x spacing between adjacent digits

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_time_wr_en  in  1  one-cycle strobe: i_time_sel/i_time_read_time valid
- i_time_sel  in  6  digit mask; bit0=S1, bit1=S2, bit2=M1, bit3=M2, bit4=H1, bit5=H2
- i_time_read_time  in  20  packed BCD: S1[3:0] S2[6:4] M1[10:7] M2[13:11] H1[17:14] H2[19:18]
- i_refresh  in  1  one-cycle strobe: redraw all six digits
- i_edit_active  in  1  set-time mode active; used only with DIGIT_CURSOR_EN
- o_cmd_valid  out  1  command valid
- i_cmd_ready  in  1  downstream accepts command
- o_cmd_idx  out  3  digit index 0..5
- o_cmd_x  out  8  DIGIT_X0 + DIGIT_PITCH*(5-idx), mod 256
- o_cmd_digit  out  4  digit value, zero-extended (S2/M2 {0,3b}, H2 {00,2b})
- o_cmd_cursor  out  1  draw digit highlighted
- o_busy  out  1  state != IDLE

## Operation
- Registers: active mask (6), snapshot time (20), pending mask (6), pending time (20), FSM {IDLE, SEND}, cursor one-hot (6, feature only).
- Request this cycle: req_mask = (i_time_wr_en ? i_time_sel : 0) | (i_refresh ? 6'h3F : 0). req_time = i_time_read_time. Refresh with no wr_en uses the last pending/snapshot time, whichever is newer.
- IDLE: if req_mask != 0, load active mask = req_mask and snapshot = req_time, then go to SEND. A request with req_mask == 0 is ignored.
- SEND: command = highest set bit of active mask. Order is H2 first, S1 last, i.e. left to right. o_cmd_digit is taken from the snapshot.
- On handshake (valid & ready), clear that bit. If the mask is still nonzero, stay in SEND.
- If the mask becomes zero: if pending (including this cycle's request) != 0, move pending into active, clear pending, stay in SEND. Otherwise go to IDLE.
- Request while in SEND (and not consumed by a load the same cycle): pending mask |= req_mask, pending time = req_time. Bits already in the active mask are still sent with the old snapshot and are redrawn later from pending.
- o_cmd_valid, idx, x, digit and cursor are stable while valid && !ready.
- Reset mid-operation clears all masks and returns to IDLE; no command is completed.

## Timing
- All outputs are registered. Reset values: o_cmd_valid=0, o_cmd_idx=0, o_cmd_x=0, o_cmd_digit=0, o_cmd_cursor=0, o_busy=0.
- Request at edge N in IDLE gives o_cmd_valid=1 from cycle N+1.
- With ready held high: one command per cycle, back-to-back. Pending is loaded with zero bubble.
- A 6-digit update with ready=1 completes in 6 cycles. o_busy falls the cycle after the last handshake.
- Simultaneous last handshake and new request: the request is loaded directly; valid stays high.

## Configuration
- DIGIT_CURSOR_EN defined:
  - On each load while i_edit_active=1: cursor one-hot = req sel.
  - The previous cursor position is OR-ed into the mask, so the old digit is redrawn plain.
  - o_cmd_cursor = 1 when idx matches the cursor.
  - When i_edit_active falls, the next load redraws the cursor digit with cursor=0.
- DIGIT_CURSOR_EN undefined: o_cmd_cursor tied 0, i_edit_active ignored, no cursor register.

## Test plan
- Reset, then wr_en with sel=6'b000001, time S1=7, ready=1 → one command idx=0, digit=7, x=88, valid for exactly 1 cycle.
- wr_en with sel=6'h3F, time 23:59:59, ready=1 → commands in order idx 5,4,3,2,1,0 with digits 2,3,5,9,5,9 on 6 consecutive cycles.
- Same as above with ready toggling 1-0-1 → outputs held stable while ready=0; no command dropped or repeated.
- During a 6-digit burst, wr_en sel=6'b000011 with S1=1, S2=2 → after the burst, idx 1 digit=2 then idx 0 digit=1, with no valid gap.
- i_refresh while IDLE → all six digits redrawn from the last time. i_rst_n pulled low mid-burst → valid=0, busy=0 immediately.
- (DIGIT_CURSOR_EN) i_edit_active=1, sel 000001 then 000010 → second update sends idx1 cursor=1, then idx0 cursor=0.

Source files
------------

// File: rtl/lcd_digit_updater.sv
// lcd_digit_updater: turns digit-changed masks from the time-keeping block into
// per-digit glyph-draw commands over a valid/ready handshake, left to right (H2 first).
// Requests arriving while busy are coalesced into a pending mask, so each digit is
// drawn with its latest value.
// Optional feature: define DIGIT_CURSOR_EN to highlight the digit being edited.
module lcd_digit_updater #(
   parameter int unsigned DIGIT_X0    = 8,
   parameter int unsigned DIGIT_PITCH = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_time_wr_en,
   input  logic [5:0]  i_time_sel,
   input  logic [19:0] i_time_read_time,
   input  logic        i_refresh,
   input  logic        i_edit_active,
   output logic        o_cmd_valid,
   input  logic        i_cmd_ready,
   output logic [2:0]  o_cmd_idx,
   output logic [7:0]  o_cmd_x,
   output logic [3:0]  o_cmd_digit,
   output logic        o_cmd_cursor,
   output logic        o_busy
);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e      state_q, state_d;
   logic [5:0]  act_mask_q, act_mask_d;
   logic [19:0] snap_time_q, snap_time_d;
   logic [5:0]  pend_mask_q, pend_mask_d;
   logic [19:0] pend_time_q, pend_time_d;

   logic [5:0]  req_mask;
   logic [19:0] req_time;
   logic [5:0]  remain;
   logic [5:0]  merged;
   logic        hs;
   logic        load;
   logic [5:0]  load_mask;
   logic [19:0] load_time;
   logic [2:0]  nxt_idx;

`ifdef DIGIT_CURSOR_EN
   logic [5:0]  cursor_q, cursor_d;
`else
   logic        unused_edit;
   assign unused_edit  = i_edit_active;
   assign o_cmd_cursor = 1'b0;
`endif

   // Highest set bit wins: H2 is drawn first.
   function automatic logic [2:0] top_idx(input logic [5:0] m);
      top_idx = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (m[i]) top_idx = 3'(i);
      end
   endfunction

   function automatic logic [3:0] digit_of(input logic [19:0] t, input logic [2:0] idx);
      case (idx)
         3'd0:    digit_of = t[3:0];
         3'd1:    digit_of = {1'b0, t[6:4]};
         3'd2:    digit_of = t[10:7];
         3'd3:    digit_of = {1'b0, t[13:11]};
         3'd4:    digit_of = t[17:14];
         3'd5:    digit_of = {2'b00, t[19:18]};
         default: digit_of = 4'd0;
      endcase
   endfunction

   function automatic logic [7:0] x_of(input logic [2:0] idx);
      x_of = 8'(DIGIT_X0 + DIGIT_PITCH * (32'd5 - 32'(idx)));
   endfunction

   // Next-state: load on idle request, drain active mask, coalesce into pending.
   always_comb begin
      req_mask    = (i_time_wr_en ? i_time_sel : 6'h00) | (i_refresh ? 6'h3F : 6'h00);
      // A refresh without new time reuses the newest time already captured.
      if (i_time_wr_en)           req_time = i_time_read_time;
      else if (pend_mask_q != '0) req_time = pend_time_q;
      else                        req_time = snap_time_q;

      hs          = o_cmd_valid && i_cmd_ready;
      state_d     = state_q;
      act_mask_d  = act_mask_q;
      snap_time_d = snap_time_q;
      pend_mask_d = pend_mask_q;
      pend_time_d = pend_time_q;
      remain      = act_mask_q;
      merged      = pend_mask_q | req_mask;
      load        = 1'b0;
      load_mask   = '0;
      load_time   = snap_time_q;
`ifdef DIGIT_CURSOR_EN
      cursor_d    = cursor_q;
`endif

      case (state_q)
         StIdle: begin
            if (req_mask != '0) begin
               load      = 1'b1;
               load_mask = req_mask;
               load_time = req_time;
            end
         end
         StSend: begin
            if (hs) remain = act_mask_q & ~(6'b000001 << o_cmd_idx);
            if (remain != '0) begin
               act_mask_d = remain;
               if (req_mask != '0) begin
                  pend_mask_d = pend_mask_q | req_mask;
                  pend_time_d = req_time;
               end
            end else if (merged != '0) begin
               load        = 1'b1;
               load_mask   = merged;
               load_time   = (req_mask != '0) ? req_time : pend_time_q;
               pend_mask_d = '0;
            end else begin
               act_mask_d = '0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         state_d     = StSend;
         snap_time_d = load_time;
`ifdef DIGIT_CURSOR_EN
         // Old cursor digit is redrawn so its highlight is removed.
         act_mask_d  = load_mask | cursor_q;
         cursor_d    = i_edit_active ? (6'b000001 << top_idx(load_mask)) : 6'h00;
`else
         act_mask_d  = load_mask;
`endif
      end
   end

   assign nxt_idx = top_idx(act_mask_d);

   // State and registered command outputs, computed from next state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= StIdle;
         act_mask_q   <= '0;
         snap_time_q  <= '0;
         pend_mask_q  <= '0;
         pend_time_q  <= '0;
         o_cmd_valid  <= 1'b0;
         o_busy       <= 1'b0;
         o_cmd_idx    <= '0;
         o_cmd_x      <= '0;
         o_cmd_digit  <= '0;
`ifdef DIGIT_CURSOR_EN
         cursor_q     <= '0;
         o_cmd_cursor <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         act_mask_q  <= act_mask_d;
         snap_time_q <= snap_time_d;
         pend_mask_q <= pend_mask_d;
         pend_time_q <= pend_time_d;
         o_cmd_valid <= (state_d == StSend);
         o_busy      <= (state_d != StIdle);
`ifdef DIGIT_CURSOR_EN
         cursor_q    <= cursor_d;
`endif
         if (state_d == StSend) begin
            o_cmd_idx    <= nxt_idx;
            o_cmd_x      <= x_of(nxt_idx);
            o_cmd_digit  <= digit_of(snap_time_d, nxt_idx);
`ifdef DIGIT_CURSOR_EN
            o_cmd_cursor <= |(cursor_d & (6'b000001 << nxt_idx));
`endif
         end
      end
   end

endmodule
